spi_master_ctrl: RTL and testbench

//  SPI master that drives the SPI slave + single-port RAM wrapper (SS_n/MOSI/MISO).

---
 rtl/spi_master_ctrl_if.sv | 21 ++
 rtl/spi_master_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Command/reply handshake between a host and spi_master_ctrl.
// The host drives commands through the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_type, cmd_data,
        input  cmd_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_data,
        output cmd_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI-slave/RAM wrapper: one framed command per handshake,
// 8-bit MISO reply captured for read-data commands.
module spi_master_ctrl #(
    parameter int unsigned RD_WAIT = 9,
    parameter int unsigned GAP     = 1
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.slave   bus,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int unsigned CW = (RD_WAIT <= 16) ? 4 : $clog2(RD_WAIT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [10:0]   frame, frame_nx;
    logic [7:0]    shift, shift_nx;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          rx_done;
    logic          ss_nx, mosi_nx;

    // One down-counter serves every timed state; each state loads length-1 on entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        frame_nx = frame;
        shift_nx = shift;
        rx_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_nx = S_SEND;
                    cnt_nx   = CW'(10);
                    frame_nx = {bus.cmd_type[1], bus.cmd_type, bus.cmd_data};
                end
            end
            S_SEND: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else if (frame[9:8] == 2'b11) begin
                    if (RD_WAIT != 0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = CW'(RD_WAIT - 1);
                    end else begin
                        state_nx = S_RECV;
                        cnt_nx   = CW'(7);
                    end
                end else begin
                    state_nx = S_GAP;
                    cnt_nx   = CW'(GAP - 1);
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    state_nx = S_RECV;
                    cnt_nx   = CW'(7);
                end
            end
            S_RECV: begin
                shift_nx = {shift[6:0], MISO};
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    state_nx = S_GAP;
                    cnt_nx   = CW'(GAP - 1);
                    rx_done  = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt != '0) cnt_nx = cnt - CW'(1);
                else           state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Pin values are derived from the next state so SS_n/MOSI come straight off flops.
    always_comb begin
        ss_nx   = !((state_nx == S_SEND) || (state_nx == S_WAIT) || (state_nx == S_RECV));
        mosi_nx = (state_nx == S_SEND) ? frame_nx[cnt_nx[3:0]] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            frame      <= '0;
            shift      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            frame      <= frame_nx;
            shift      <= shift_nx;
            rx_valid_q <= rx_done;
            if (rx_done) rx_data_q <= shift_nx;
            SS_n       <= ss_nx;
            MOSI       <= mosi_nx;
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default build (dut1) and RD_WAIT=0/GAP=3 build (dut2),
// each with a small slave model that counts SS_n-low cycles and serves the reply on MISO.
module tb_spi_master_ctrl;

    localparam int unsigned RDW1 = 9;
    localparam int unsigned GAP1 = 1;
    localparam int unsigned RDW2 = 0;
    localparam int unsigned GAP2 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic ss1, mosi1, ss2, mosi2;
    logic miso1 = 1'b1;
    logic miso2 = 1'b1;

    spi_master_ctrl_if b1();
    spi_master_ctrl_if b2();

    spi_master_ctrl #(.RD_WAIT(RDW1), .GAP(GAP1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1)
    );
    spi_master_ctrl #(.RD_WAIT(RDW2), .GAP(GAP2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2), .SS_n(ss2), .MOSI(mosi2), .MISO(miso2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Slave models: MISO idles at 1 so any sampling outside RECV corrupts the reply.
    logic [7:0]  rep1 = 8'hC3;
    logic [7:0]  rep2 = 8'hA5;
    int          len1[$], hi1[$], len2[$], hi2[$];
    logic [63:0] bits1[$], bits2[$];
    int          lo1 = 0, hr1 = 0, lo2 = 0, hr2 = 0;
    logic [63:0] sh1 = '0, sh2 = '0;
    int          rxv1 = 0, mbad = 0;
    logic        rxe1 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            lo1 = 0; hr1 = 0; sh1 = '0; miso1 = 1'b1;
        end else begin
            if (!ss1) begin
                if (lo1 == 0) hi1.push_back(hr1);
                lo1++;
                hr1 = 0;
                sh1 = {sh1[62:0], mosi1};
                miso1 = (lo1 >= 21 && lo1 <= 28) ? rep1[28 - lo1] : 1'b1;
            end else begin
                if (lo1 > 0) begin
                    len1.push_back(lo1);
                    bits1.push_back(sh1);
                    rxe1 = b1.rx_valid;
                end
                lo1 = 0; sh1 = '0; hr1++; miso1 = 1'b1;
                if (mosi1) mbad++;
            end
            if (b1.rx_valid) rxv1++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            lo2 = 0; hr2 = 0; sh2 = '0; miso2 = 1'b1;
        end else begin
            if (!ss2) begin
                if (lo2 == 0) hi2.push_back(hr2);
                lo2++;
                hr2 = 0;
                sh2 = {sh2[62:0], mosi2};
                miso2 = (lo2 >= 12 && lo2 <= 19) ? rep2[19 - lo2] : 1'b1;
            end else begin
                if (lo2 > 0) begin
                    len2.push_back(lo2);
                    bits2.push_back(sh2);
                end
                lo2 = 0; sh2 = '0; hr2++; miso2 = 1'b1;
                if (mosi2) mbad++;
            end
        end
    end

    function automatic logic rdy(input bit sel);
        return sel ? b2.cmd_ready : b1.cmd_ready;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? b2.busy : b1.busy;
    endfunction

    function automatic int nwin(input bit sel);
        return sel ? len2.size() : len1.size();
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [1:0] t, input logic [7:0] d);
        if (sel) begin
            b2.cmd_valid = v; b2.cmd_type = t; b2.cmd_data = d;
        end else begin
            b1.cmd_valid = v; b1.cmd_type = t; b1.cmd_data = d;
        end
    endtask

    // Called at negedge+1; returns at negedge+1 just after the command was taken.
    task automatic issue(input bit sel, input logic [1:0] t, input logic [7:0] d);
        int n = 0;
        drive(sel, 1'b1, t, d);
        while (!rdy(sel) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) check("accept_timeout", 64'(n), 64'd0);
        @(negedge clk); #1;
    endtask

    // Drop valid and scramble the inputs to show the in-flight frame ignores them.
    task automatic cmd_drop(input bit sel);
        if (sel) begin
            b2.cmd_valid = 1'b0; b2.cmd_type = ~b2.cmd_type; b2.cmd_data = ~b2.cmd_data;
        end else begin
            b1.cmd_valid = 1'b0; b1.cmd_type = ~b1.cmd_type; b1.cmd_data = ~b1.cmd_data;
        end
    endtask

    // Waits for window number w0+1 to close, then counts busy cycles left before IDLE.
    task automatic wait_done(input bit sel, input int w0, output int g);
        int n = 0;
        while (nwin(sel) <= w0 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) check("frame_timeout", 64'(n), 64'd0);
        g = 0;
        while (bsy(sel) && g < 20) begin
            g++; @(negedge clk); #1;
        end
    endtask

    int w, g, n, rxs;

    initial begin
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        drive(1'b1, 1'b0, 2'b00, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ss_n",      64'(ss1),          64'd1);
        check("rst_mosi",      64'(mosi1),        64'd0);
        check("rst_rx_valid",  64'(b1.rx_valid),  64'd0);
        check("rst_rx_data",   64'(b1.rx_data),   64'h00);
        check("rst_cmd_ready", 64'(b1.cmd_ready), 64'd1);
        check("rst_busy",      64'(b1.busy),      64'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        // 1: wr addr 5A -> F = 0_00_01011010
        w = nwin(0);
        issue(0, 2'b00, 8'h5A); cmd_drop(0);
        wait_done(0, w, g);
        check("t1_len",  64'(len1[$]), 64'd11);
        check("t1_bits", bits1[$],     64'h05A);
        check("t1_gap",  64'(g),       64'(GAP1));

        // 2: wr data F0 -> F = 0_01_11110000
        w = nwin(0);
        issue(0, 2'b01, 8'hF0); cmd_drop(0);
        wait_done(0, w, g);
        check("t2_len",  64'(len1[$]), 64'd11);
        check("t2_bits", bits1[$],     64'h1F0);
        check("t2_rxv",  64'(rxv1),    64'd0);

        // 3: rd data -> F = 1_11_00000000 then 17 zero bits, reply C3
        w = nwin(0);
        issue(0, 2'b11, 8'h00); cmd_drop(0);
        wait_done(0, w, g);
        check("t3_len",     64'(len1[$]),     64'd28);
        check("t3_bits",    bits1[$],         64'h700 << 17);
        check("t3_rx_data", 64'(b1.rx_data),  64'hC3);
        check("t3_rxv_end", 64'(rxe1),        64'd1);
        check("t3_rxv_cnt", 64'(rxv1),        64'd1);

        // 4: valid held across three commands; the IDLE accept cycle adds one high cycle
        w = nwin(0);
        issue(0, 2'b00, 8'h11);
        issue(0, 2'b01, 8'h22);
        issue(0, 2'b10, 8'h33);
        cmd_drop(0);
        wait_done(0, w + 2, g);
        check("t4_hi_a",   64'(hi1[$-1]),    64'(GAP1 + 1));
        check("t4_hi_b",   64'(hi1[$]),      64'(GAP1 + 1));
        check("t4_bits_a", bits1[$-2],       64'h011);
        check("t4_bits_b", bits1[$-1],       64'h122);
        check("t4_bits_c", bits1[$],         64'h633);
        check("t4_rx_hold", 64'(b1.rx_data), 64'hC3);

        // 5: reset during RECV (low cycle 24), then a clean rd addr 01 frame
        rxs = rxv1;
        issue(0, 2'b11, 8'h00); cmd_drop(0);
        n = 0;
        while (lo1 != 24 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) check("t5_reach_timeout", 64'(n), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("t5_ss_async",   64'(ss1),   64'd1);
        check("t5_mosi_async", 64'(mosi1), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("t5_rx_data", 64'(b1.rx_data), 64'h00);
        check("t5_rxv_cnt", 64'(rxv1),       64'(rxs));
        w = nwin(0);
        issue(0, 2'b10, 8'h01); cmd_drop(0);
        wait_done(0, w, g);
        check("t5_len",  64'(len1[$]), 64'd11);
        check("t5_bits", bits1[$],     64'h601);

        // 6: RD_WAIT=0, GAP=3 build, rd data then wr addr with valid held
        w = nwin(1);
        issue(1, 2'b11, 8'h00);
        issue(1, 2'b00, 8'h44);
        cmd_drop(1);
        wait_done(1, w + 1, g);
        check("t6_len_rd",  64'(len2[$-1]),   64'd19);
        check("t6_bits_rd", bits2[$-1],       64'h700 << 8);
        check("t6_hi",      64'(hi2[$]),      64'(GAP2 + 1));
        check("t6_rx_data", 64'(b2.rx_data),  64'hA5);
        check("t6_len_wr",  64'(len2[$]),     64'd11);
        check("t6_gap",     64'(g),           64'(GAP2));

        check("mosi_while_ss_high", 64'(mbad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
